// File: rtl/hub75_rx_monitor.sv
// hub75_rx_monitor
//   Panel-side receiver model for a HUB75 link. All panel inputs are brought
//   into clk through 2-FF synchronisers; the shift stream is deserialised into
//   per-pixel strobes, each latched row is reported with its pixel count and
//   OE on-time, and protocol violations are collected in sticky flags.
//
// Ports
//   clk, rst            system clock, asynchronous active-low reset
//   CLK_MOD, LAT, OE    HUB75 shift clock, latch, output enable (active-low)
//   A, B                row address, row = {B,A}
//   R1..B2              colour bits of the upper and lower half
//   err_clr             1-cycle pulse clearing err_flags
//   pix_valid/col/data  pixel strobe, column index, {R1,G1,B1,R2,G2,B2}
//   line_valid/row/len  row-latched strobe, {B,A}, pixels since previous latch
//   line_oe_cnt         clk cycles with OE low since previous latch (saturating)
//   err_flags           sticky {timeout, lat_during_oe, short_row, overflow}
module hub75_rx_monitor #(
  parameter int COLS     = 64,
  parameter int TIMEOUT  = 4096,
  parameter int OE_CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       CLK_MOD,
  input  logic                       LAT,
  input  logic                       OE,
  input  logic                       A,
  input  logic                       B,
  input  logic                       R1,
  input  logic                       G1,
  input  logic                       B1,
  input  logic                       R2,
  input  logic                       G2,
  input  logic                       B2,
  input  logic                       err_clr,
  output logic                       pix_valid,
  output logic [$clog2(COLS)-1:0]    pix_col,
  output logic [5:0]                 pix_data,
  output logic                       line_valid,
  output logic [1:0]                 line_row,
  output logic [$clog2(COLS+1)-1:0]  line_len,
  output logic [OE_CNT_W-1:0]        line_oe_cnt,
  output logic [3:0]                 err_flags
);

  localparam int COL_W  = $clog2(COLS);
  localparam int LEN_W  = $clog2(COLS+1);
  localparam int IDLE_W = $clog2(TIMEOUT);

  typedef enum logic {SYNC_WAIT, RUN} state_t;

  // bit map: 10 CLK_MOD, 9 LAT, 8 OE, 7 B, 6 A, 5:0 RGB
  logic [10:0]         pad_vec, sync1, sync2;
  logic [1:0]          prev;
  state_t              state;
  logic [LEN_W-1:0]    col, col_acc;
  logic [OE_CNT_W-1:0] oe_cnt, oe_acc;
  logic [IDLE_W-1:0]   idle;
  logic                clk_rise, lat_rise, pix_ok, oe_low, idle_hit;
  logic [3:0]          new_err;

  assign pad_vec = {CLK_MOD, LAT, OE, B, A, R1, G1, B1, R2, G2, B2};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pad_vec;
      sync2 <= sync1;
    end
  end

  always_comb begin
    clk_rise = sync2[10] & ~prev[1];
    lat_rise = sync2[9] & ~prev[0];
    oe_low   = ~sync2[8];
    pix_ok   = clk_rise && (col < LEN_W'(COLS));
    // a pixel arriving together with LAT belongs to the row being latched
    col_acc  = col + LEN_W'(pix_ok);
    oe_acc   = (oe_low && (oe_cnt != '1)) ? oe_cnt + 1'b1 : oe_cnt;
    idle_hit = (idle == IDLE_W'(TIMEOUT-1)) && !clk_rise && !lat_rise;
    new_err  = '0;
    if (state == RUN) begin
      new_err[0] = clk_rise && !pix_ok;
      new_err[1] = lat_rise && (col_acc != LEN_W'(COLS));
      new_err[2] = lat_rise && oe_low;
      new_err[3] = idle_hit;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= SYNC_WAIT;
      prev        <= '0;
      col         <= '0;
      oe_cnt      <= '0;
      idle        <= '0;
      pix_valid   <= 1'b0;
      pix_col     <= '0;
      pix_data    <= '0;
      line_valid  <= 1'b0;
      line_row    <= '0;
      line_len    <= '0;
      line_oe_cnt <= '0;
      err_flags   <= '0;
    end else begin
      pix_valid  <= 1'b0;
      line_valid <= 1'b0;
      prev       <= sync2[10:9];
      // set beats clear when both happen in one cycle
      err_flags  <= (err_flags & {4{~err_clr}}) | new_err;
      case (state)
        SYNC_WAIT: begin
          idle <= '0;
          if (lat_rise) begin
            state  <= RUN;
            col    <= '0;
            oe_cnt <= '0;
          end
        end
        RUN: begin
          if (pix_ok) begin
            pix_valid <= 1'b1;
            pix_col   <= col[COL_W-1:0];
            pix_data  <= sync2[5:0];
          end
          if (lat_rise) begin
            line_valid  <= 1'b1;
            line_row    <= sync2[7:6];
            line_len    <= col_acc;
            line_oe_cnt <= oe_acc;
            col         <= '0;
            oe_cnt      <= '0;
          end else begin
            col    <= col_acc;
            oe_cnt <= oe_acc;
          end
          if (clk_rise || lat_rise) begin
            idle <= '0;
          end else if (idle_hit) begin
            state  <= SYNC_WAIT;
            col    <= '0;
            oe_cnt <= '0;
            idle   <= '0;
          end else begin
            idle <= idle + 1'b1;
          end
        end
        default: state <= SYNC_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_rx_monitor.sv
module tb_hub75_rx_monitor;

  localparam int TIMEOUT = 4096;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic CLK_MOD = 1'b0, LAT = 1'b0, OE = 1'b1, A = 1'b0, B = 1'b0;
  logic R1 = 1'b0, G1 = 1'b0, B1 = 1'b0, R2 = 1'b0, G2 = 1'b0, B2 = 1'b0;
  logic err_clr = 1'b0;
  logic        pix_valid;
  logic [5:0]  pix_col;
  logic [5:0]  pix_data;
  logic        line_valid;
  logic [1:0]  line_row;
  logic [6:0]  line_len;
  logic [15:0] line_oe_cnt;
  logic [3:0]  err_flags;

  int total = 0;
  int bad = 0;

  int pix_cnt = 0;
  int line_cnt = 0;
  int both_cnt = 0;
  logic [5:0] log_col [0:1023];
  logic [5:0] log_data[0:1023];

  hub75_rx_monitor #(.COLS(64), .TIMEOUT(TIMEOUT), .OE_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .CLK_MOD(CLK_MOD), .LAT(LAT), .OE(OE), .A(A), .B(B),
    .R1(R1), .G1(G1), .B1(B1), .R2(R2), .G2(G2), .B2(B2), .err_clr(err_clr),
    .pix_valid(pix_valid), .pix_col(pix_col), .pix_data(pix_data),
    .line_valid(line_valid), .line_row(line_row), .line_len(line_len),
    .line_oe_cnt(line_oe_cnt), .err_flags(err_flags)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (pix_valid) begin
      if (pix_cnt < 1024) begin
        log_col[pix_cnt]  = pix_col;
        log_data[pix_cnt] = pix_data;
      end
      pix_cnt++;
    end
    if (line_valid) begin
      line_cnt++;
      if (pix_valid) both_cnt++;
    end
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_pixel(input logic [5:0] d);
    {R1, G1, B1, R2, G2, B2} = d;
    CLK_MOD = 1'b0;
    clks(2);
    CLK_MOD = 1'b1;
    clks(2);
    CLK_MOD = 1'b0;
  endtask

  task automatic lat_pulse(input logic [1:0] row);
    {B, A} = row;
    clks(2);
    LAT = 1'b1;
    clks(3);
    LAT = 1'b0;
    clks(5);
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    clks(1);
    err_clr = 1'b0;
    clks(1);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clks(3);
    total++;
    if ({pix_valid, pix_col, pix_data, line_valid, line_row, line_len, line_oe_cnt, err_flags} !== 43'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0",
               {pix_valid, pix_col, pix_data, line_valid, line_row, line_len, line_oe_cnt, err_flags});
    end
    rst = 1'b1;
    clks(2);
  endtask

  task automatic test_sync_wait();
    int p0, l0;
    p0 = pix_cnt;
    l0 = line_cnt;
    for (int i = 0; i < 64; i++) shift_pixel(i[5:0]);
    clks(4);
    total++;
    if (pix_cnt - p0 !== 0) begin
      bad++;
      $display("FAIL syncwait_no_pix: got %0d want 0", pix_cnt - p0);
    end
    lat_pulse(2'b01);
    total++;
    if (line_cnt - l0 !== 0) begin
      bad++;
      $display("FAIL first_lat_no_line: got %0d want 0", line_cnt - l0);
    end
  endtask

  task automatic test_full_row();
    int p0, l0;
    p0 = pix_cnt;
    l0 = line_cnt;
    for (int i = 0; i < 64; i++) shift_pixel(i[5:0]);
    lat_pulse(2'b10);
    total++;
    if (pix_cnt - p0 !== 64) begin
      bad++;
      $display("FAIL full_row_pix_count: got %0d want 64", pix_cnt - p0);
    end
    for (int i = 0; i < 64; i++) begin
      total++;
      if (log_col[p0+i] !== i[5:0] || log_data[p0+i] !== i[5:0]) begin
        bad++;
        $display("FAIL full_row_pixel%0d: got col=%0d data=%h want col=%0d data=%h",
                 i, log_col[p0+i], log_data[p0+i], i, i[5:0]);
      end
    end
    total++;
    if (line_cnt - l0 !== 1) begin
      bad++;
      $display("FAIL full_row_line_count: got %0d want 1", line_cnt - l0);
    end
    total++;
    if ({line_row, line_len, line_oe_cnt} !== {2'd2, 7'd64, 16'd0}) begin
      bad++;
      $display("FAIL full_row_line: got row=%0d len=%0d oe=%0d want row=2 len=64 oe=0",
               line_row, line_len, line_oe_cnt);
    end
    total++;
    if (err_flags !== 4'b0000) begin
      bad++;
      $display("FAIL full_row_err: got %b want 0000", err_flags);
    end
  endtask

  task automatic test_overflow_short();
    int p0;
    p0 = pix_cnt;
    for (int i = 0; i < 65; i++) shift_pixel(6'h3F - i[5:0]);
    lat_pulse(2'b01);
    total++;
    if (pix_cnt - p0 !== 64) begin
      bad++;
      $display("FAIL overflow_pix_count: got %0d want 64", pix_cnt - p0);
    end
    total++;
    if (line_len !== 7'd64 || line_row !== 2'd1) begin
      bad++;
      $display("FAIL overflow_line: got len=%0d row=%0d want len=64 row=1", line_len, line_row);
    end
    total++;
    if (err_flags !== 4'b0001) begin
      bad++;
      $display("FAIL overflow_flag: got %b want 0001", err_flags);
    end
    for (int i = 0; i < 10; i++) shift_pixel(i[5:0]);
    lat_pulse(2'b11);
    total++;
    if (line_len !== 7'd10 || line_row !== 2'd3) begin
      bad++;
      $display("FAIL short_row_line: got len=%0d row=%0d want len=10 row=3", line_len, line_row);
    end
    total++;
    if (err_flags !== 4'b0011) begin
      bad++;
      $display("FAIL short_row_flag: got %b want 0011", err_flags);
    end
  endtask

  task automatic test_oe_count();
    pulse_err_clr();
    total++;
    if (err_flags !== 4'b0000) begin
      bad++;
      $display("FAIL err_clr_first: got %b want 0000", err_flags);
    end
    for (int i = 0; i < 64; i++) shift_pixel(6'h15);
    {B, A} = 2'b00;
    clks(2);
    OE = 1'b0;
    clks(199);
    LAT = 1'b1;
    clks(1);
    OE = 1'b1;
    clks(2);
    LAT = 1'b0;
    clks(5);
    total++;
    if (line_oe_cnt !== 16'd200 || line_len !== 7'd64) begin
      bad++;
      $display("FAIL oe_count: got oe=%0d len=%0d want oe=200 len=64", line_oe_cnt, line_len);
    end
    total++;
    if (err_flags !== 4'b0100) begin
      bad++;
      $display("FAIL lat_during_oe: got %b want 0100", err_flags);
    end
    pulse_err_clr();
    total++;
    if (err_flags !== 4'b0000) begin
      bad++;
      $display("FAIL err_clr_second: got %b want 0000", err_flags);
    end
  endtask

  task automatic test_back_to_back();
    int p0, b0;
    p0 = pix_cnt;
    b0 = both_cnt;
    for (int i = 0; i < 63; i++) shift_pixel(6'h2A);
    {R1, G1, B1, R2, G2, B2} = 6'h31;
    {B, A} = 2'b01;
    CLK_MOD = 1'b0;
    clks(2);
    CLK_MOD = 1'b1;
    LAT = 1'b1;
    clks(3);
    CLK_MOD = 1'b0;
    LAT = 1'b0;
    clks(5);
    total++;
    if (both_cnt - b0 !== 1) begin
      bad++;
      $display("FAIL same_cycle_strobes: got %0d want 1", both_cnt - b0);
    end
    total++;
    if (pix_cnt - p0 !== 64 || pix_col !== 6'd63 || pix_data !== 6'h31) begin
      bad++;
      $display("FAIL same_cycle_pixel: got n=%0d col=%0d data=%h want n=64 col=63 data=31",
               pix_cnt - p0, pix_col, pix_data);
    end
    total++;
    if (line_len !== 7'd64 || err_flags !== 4'b0000) begin
      bad++;
      $display("FAIL same_cycle_line: got len=%0d err=%b want len=64 err=0000", line_len, err_flags);
    end
  endtask

  task automatic test_timeout_reset();
    int p0, l0;
    clks(TIMEOUT - 40);
    total++;
    if (err_flags[3] !== 1'b0) begin
      bad++;
      $display("FAIL timeout_early: got %b want 0", err_flags[3]);
    end
    clks(60);
    total++;
    if (err_flags !== 4'b1000) begin
      bad++;
      $display("FAIL timeout_flag: got %b want 1000", err_flags);
    end
    p0 = pix_cnt;
    for (int i = 0; i < 5; i++) shift_pixel(i[5:0]);
    clks(4);
    total++;
    if (pix_cnt - p0 !== 0) begin
      bad++;
      $display("FAIL timeout_syncwait: got %0d want 0", pix_cnt - p0);
    end
    lat_pulse(2'b00);
    for (int i = 0; i < 10; i++) shift_pixel(6'h3F);
    rst = 1'b0;
    clks(2);
    total++;
    if ({pix_valid, pix_col, pix_data, line_valid, line_row, line_len, line_oe_cnt, err_flags} !== 43'd0) begin
      bad++;
      $display("FAIL midrow_reset: got %h want 0",
               {pix_valid, pix_col, pix_data, line_valid, line_row, line_len, line_oe_cnt, err_flags});
    end
    rst = 1'b1;
    clks(2);
    p0 = pix_cnt;
    l0 = line_cnt;
    for (int i = 0; i < 4; i++) shift_pixel(6'h0F);
    lat_pulse(2'b10);
    total++;
    if (pix_cnt - p0 !== 0 || line_cnt - l0 !== 0) begin
      bad++;
      $display("FAIL resync_quiet: got pix=%0d line=%0d want 0 0", pix_cnt - p0, line_cnt - l0);
    end
    p0 = pix_cnt;
    for (int i = 0; i < 3; i++) shift_pixel(6'h20 + i[5:0]);
    lat_pulse(2'b11);
    total++;
    if (pix_cnt - p0 !== 3 || log_col[p0+2] !== 6'd2 || log_data[p0+2] !== 6'h22) begin
      bad++;
      $display("FAIL resync_pixels: got n=%0d col=%0d data=%h want n=3 col=2 data=22",
               pix_cnt - p0, log_col[p0+2], log_data[p0+2]);
    end
    total++;
    if (line_cnt - l0 !== 1 || line_len !== 7'd3 || line_row !== 2'd3 || err_flags !== 4'b0010) begin
      bad++;
      $display("FAIL resync_line: got n=%0d len=%0d row=%0d err=%b want n=1 len=3 row=3 err=0010",
               line_cnt - l0, line_len, line_row, err_flags);
    end
  endtask

  initial begin
    test_reset();
    test_sync_wait();
    test_full_row();
    test_overflow_short();
    test_oe_count();
    test_back_to_back();
    test_timeout_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
